axis_frame_capture: RTL and testbench

- AXI-Stream receiver that captures incoming frames into a double-banked block memory. It is the inbound counterpart of the memory-to-stream frame player.
- A simple backend read port (rd/raddr/rdata/rvalid, same style as the axi_config backend) lets software read a completed frame, then release its bank.
- Two banks allow one frame to be read while the next one is being captured.

---
 rtl/axis_frame_capture.sv | 170 +++++++++++++++++
 tb/tb_axis_frame_capture.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_capture.sv
// AXI-Stream frame capture into a double-banked memory.
// Software reads a completed bank, then releases it.
module axis_frame_capture #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_MEMDEPTH  = 1024,
    parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [G_DATAWIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    input  logic                   rd,
    input  logic [G_ADDRWIDTH-2:0] raddr,
    output logic [G_DATAWIDTH-1:0] rdata,
    output logic                   rvalid,
    output logic                   frame_avail,
    output logic [G_ADDRWIDTH-1:0] frame_len,
    output logic                   frame_trunc,
    input  logic                   rel,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int OW = G_ADDRWIDTH - 1;
    localparam int B  = G_MEMDEPTH / 2;
    localparam logic [OW-1:0]          LAST_OFF = OW'(B - 1);
    localparam logic [G_ADDRWIDTH-1:0] B_LEN    = G_ADDRWIDTH'(B);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_DROP,
        WR_WAIT
    } wr_state_t;

    wr_state_t state_q, state_nxt;
    logic                   tready_q, tready_nxt;
    logic                   wr_bank_q, wr_bank_nxt;
    logic                   rd_bank_q, rd_bank_nxt;
    logic [OW-1:0]          wcnt_q, wcnt_nxt;
    logic [1:0]             full_q, full_nxt;
    logic [1:0]             trunc_q, trunc_nxt;
    logic [1:0][G_ADDRWIDTH-1:0] len_q, len_nxt;
    logic                   ovf_q, ovf_nxt;

    logic                   beat;
    logic                   do_rel;
    logic                   we;
    logic                   commit;
    logic                   set_ovf;
    logic [G_ADDRWIDTH-1:0] commit_len;
    logic                   commit_trunc;

    logic [G_DATAWIDTH-1:0] mem [G_MEMDEPTH];

    assign beat   = s_axis_tvalid && tready_q;
    assign do_rel = rel && full_q[rd_bank_q];

    always_comb begin
        state_nxt    = state_q;
        wr_bank_nxt  = wr_bank_q;
        rd_bank_nxt  = rd_bank_q;
        wcnt_nxt     = wcnt_q;
        full_nxt     = full_q;
        trunc_nxt    = trunc_q;
        len_nxt      = len_q;
        we           = 1'b0;
        commit       = 1'b0;
        set_ovf      = 1'b0;
        commit_len   = '0;
        commit_trunc = 1'b0;

        if (do_rel) begin
            full_nxt[rd_bank_q] = 1'b0;
            rd_bank_nxt         = ~rd_bank_q;
        end

        unique case (state_q)
            WR_IDLE: state_nxt = WR_DATA;
            WR_DATA: begin
                if (beat) begin
                    we       = 1'b1;
                    wcnt_nxt = wcnt_q + 1'b1;
                    if (s_axis_tlast) begin
                        commit     = 1'b1;
                        commit_len = {1'b0, wcnt_q} + 1'b1;
                    end else if (wcnt_q == LAST_OFF) begin
                        set_ovf   = 1'b1;
                        state_nxt = WR_DROP;
                    end
                end
            end
            WR_DROP: begin
                if (beat && s_axis_tlast) begin
                    commit       = 1'b1;
                    commit_len   = B_LEN;
                    commit_trunc = 1'b1;
                end
            end
            WR_WAIT: begin
                if (!full_q[wr_bank_q])
                    state_nxt = WR_DATA;
            end
            default: state_nxt = WR_IDLE;
        endcase

        // Release is applied first so a same-cycle free of the other bank
        // lets the writer keep streaming without a stall.
        if (commit) begin
            full_nxt[wr_bank_q]  = 1'b1;
            len_nxt[wr_bank_q]   = commit_len;
            trunc_nxt[wr_bank_q] = commit_trunc;
            wr_bank_nxt          = ~wr_bank_q;
            wcnt_nxt             = '0;
            state_nxt = full_nxt[~wr_bank_q] ? WR_WAIT : WR_DATA;
        end

        tready_nxt = (state_nxt == WR_DATA) || (state_nxt == WR_DROP);
        ovf_nxt    = set_ovf || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WR_IDLE;
            tready_q  <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wcnt_q    <= '0;
            full_q    <= '0;
            trunc_q   <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            tready_q  <= tready_nxt;
            wr_bank_q <= wr_bank_nxt;
            rd_bank_q <= rd_bank_nxt;
            wcnt_q    <= wcnt_nxt;
            full_q    <= full_nxt;
            trunc_q   <= trunc_nxt;
            len_q     <= len_nxt;
            ovf_q     <= ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[{wr_bank_q, wcnt_q}] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd)
                rdata <= mem[{rd_bank_q, raddr}];
        end
    end

    assign s_axis_tready = tready_q;
    assign frame_avail   = full_q[rd_bank_q];
    assign frame_len     = len_q[rd_bank_q];
    assign frame_trunc   = trunc_q[rd_bank_q];
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture with a 16-word memory (8-word banks).
module tb_axis_frame_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        rd;
    logic [2:0]  raddr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        avail;
    logic [3:0]  flen;
    logic        ftrunc;
    logic        rel;
    logic        ovf;
    logic        clr_ovf;

    int vectors = 0;
    int errors  = 0;

    axis_frame_capture #(
        .G_DATAWIDTH(32),
        .G_MEMDEPTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tlast (tlast),
        .s_axis_tready(tready),
        .rd           (rd),
        .raddr        (raddr),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .frame_avail  (avail),
        .frame_len    (flen),
        .frame_trunc  (ftrunc),
        .rel          (rel),
        .overflow     (ovf),
        .clr_ovf      (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l,
                        input bit must_ready, input logic rl);
        int n = 0;
        if (must_ready)
            chk("tready_at_beat", {31'b0, tready}, 32'd1);
        while (tready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        if (n == 50)
            chk("tready_timeout", {31'b0, tready}, 32'd1);
        tdata  = d;
        tvalid = 1'b1;
        tlast  = l;
        rel    = rl;
        tick;
        tvalid = 1'b0;
        tlast  = 1'b0;
        rel    = 1'b0;
    endtask

    task automatic frame(input logic [31:0] base, input int n,
                         input bit must_ready);
        for (int i = 0; i < n; i++)
            beat(base + 32'(i), (i == n - 1), must_ready, 1'b0);
    endtask

    task automatic read(input logic [2:0] off, input logic [31:0] exp,
                        input string tag);
        rd    = 1'b1;
        raddr = off;
        tick;
        rd = 1'b0;
        chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        chk(tag, rdata, exp);
        tick;
        chk({tag, "_rvalid_off"}, {31'b0, rvalid}, 32'd0);
    endtask

    task automatic pulse_rel;
        rel = 1'b1;
        tick;
        rel = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        tdata   = '0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        rd      = 1'b0;
        raddr   = '0;
        rel     = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) tick;

        chk("rst_tready", {31'b0, tready}, 32'd0);
        chk("rst_avail",  {31'b0, avail},  32'd0);
        chk("rst_len",    {28'b0, flen},   32'd0);
        chk("rst_trunc",  {31'b0, ftrunc}, 32'd0);
        chk("rst_ovf",    {31'b0, ovf},    32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata",  rdata,           32'd0);

        rst = 1'b0;
        chk("idle_tready", {31'b0, tready}, 32'd0);
        tick;
        chk("up_tready", {31'b0, tready}, 32'd1);

        // 5-beat frame into bank 0
        frame(32'h10, 5, 1'b1);
        chk("f5_avail", {31'b0, avail},  32'd1);
        chk("f5_len",   {28'b0, flen},   32'd5);
        chk("f5_trunc", {31'b0, ftrunc}, 32'd0);
        for (int i = 0; i < 5; i++)
            read(3'(i), 32'h10 + 32'(i), "f5_rdata");
        pulse_rel;
        chk("f5_rel_avail", {31'b0, avail}, 32'd0);

        // three back-to-back frames, no release in between
        frame(32'h20, 4, 1'b1);
        frame(32'h30, 4, 1'b1);
        chk("b2b_stall", {31'b0, tready}, 32'd0);
        chk("b2b_len1",  {28'b0, flen},   32'd4);
        read(3'd0, 32'h20, "b2b_f1_d0");
        read(3'd3, 32'h23, "b2b_f1_d3");
        tick;
        chk("b2b_stall2", {31'b0, tready}, 32'd0);
        pulse_rel;
        chk("b2b_avail2", {31'b0, avail}, 32'd1);
        chk("b2b_len2",   {28'b0, flen},  32'd4);
        tick;
        chk("b2b_resume", {31'b0, tready}, 32'd1);
        frame(32'h40, 4, 1'b1);
        read(3'd0, 32'h30, "b2b_f2_d0");
        read(3'd2, 32'h32, "b2b_f2_d2");
        pulse_rel;
        chk("b2b_avail3", {31'b0, avail}, 32'd1);
        chk("b2b_len3",   {28'b0, flen},  32'd4);
        read(3'd0, 32'h40, "b2b_f3_d0");
        read(3'd3, 32'h43, "b2b_f3_d3");
        pulse_rel;
        chk("b2b_empty", {31'b0, avail}, 32'd0);
        tick;
        chk("b2b_ready", {31'b0, tready}, 32'd1);

        // single-beat frame, then commit and release in the same cycle
        beat(32'h55, 1'b1, 1'b1, 1'b0);
        chk("one_avail", {31'b0, avail}, 32'd1);
        chk("one_len",   {28'b0, flen},  32'd1);
        read(3'd0, 32'h55, "one_d0");
        beat(32'hE0, 1'b0, 1'b1, 1'b0);
        beat(32'hE1, 1'b1, 1'b1, 1'b1);
        chk("cc_avail",  {31'b0, avail},  32'd1);
        chk("cc_len",    {28'b0, flen},   32'd2);
        chk("cc_trunc",  {31'b0, ftrunc}, 32'd0);
        chk("cc_tready", {31'b0, tready}, 32'd1);
        read(3'd1, 32'hE1, "cc_d1");
        pulse_rel;
        chk("cc_rel_avail", {31'b0, avail}, 32'd0);
        pulse_rel;
        chk("ign_avail", {31'b0, avail}, 32'd0);
        read(3'd0, 32'h55, "ign_bank0");

        // 11-beat frame truncated at 8 words
        frame(32'h60, 11, 1'b1);
        chk("tr_avail", {31'b0, avail},  32'd1);
        chk("tr_len",   {28'b0, flen},   32'd8);
        chk("tr_trunc", {31'b0, ftrunc}, 32'd1);
        chk("tr_ovf",   {31'b0, ovf},    32'd1);
        read(3'd0, 32'h60, "tr_d0");
        read(3'd7, 32'h67, "tr_d7");
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("tr_clr_ovf", {31'b0, ovf},    32'd0);
        chk("tr_len_kept", {28'b0, flen},  32'd8);
        pulse_rel;

        // reset in the middle of a frame, with another frame pending
        beat(32'h7F, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_avail", {31'b0, avail}, 32'd1);
        beat(32'h70, 1'b0, 1'b1, 1'b0);
        beat(32'h71, 1'b0, 1'b1, 1'b0);
        tdata  = 32'h72;
        tvalid = 1'b1;
        rst    = 1'b1;
        tick;
        tvalid = 1'b0;
        tick;
        chk("mr_avail",  {31'b0, avail},  32'd0);
        chk("mr_tready", {31'b0, tready}, 32'd0);
        chk("mr_ovf",    {31'b0, ovf},    32'd0);
        chk("mr_len",    {28'b0, flen},   32'd0);
        rst = 1'b0;
        tick;
        chk("mr_ready", {31'b0, tready}, 32'd1);
        frame(32'h80, 2, 1'b1);
        chk("mr_f_avail", {31'b0, avail}, 32'd1);
        chk("mr_f_len",   {28'b0, flen},  32'd2);
        read(3'd0, 32'h80, "mr_d0");
        read(3'd1, 32'h81, "mr_d1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
